// File: rtl/mixer_seq_pkg.sv
// mixer_seq_pkg: shared state encoding and defaults for the mixer LO sequencer
package mixer_seq_pkg;
   typedef enum logic [1:0] {IDLE, SETTLE, RUN, DONE} state_e;
   localparam int DEAD_CYC_DEF = 1;
endpackage

// File: rtl/lo_phase_gen.sv
// lo_phase_gen: period position counter and non-overlapping LO pair with dead time
module lo_phase_gen #(
   parameter int CNT_W    = 16,
   parameter int DEAD_CYC = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             first,
   input  logic [CNT_W-1:0] half,
   output logic             lo_p,
   output logic             lo_n,
   output logic             lo_sync,
   output logic             period_end
);
   localparam logic [CNT_W:0] ONE  = (CNT_W+1)'(1);
   localparam logic [CNT_W:0] DEAD = (CNT_W+1)'(DEAD_CYC);
   logic [CNT_W:0] cnt_q, cnt_d, hp, per, on_len;
   logic lo_p_q, lo_p_d, lo_n_q, lo_n_d, lo_sync_q, lo_sync_d;
   // next position in the period and the LO levels for that position
   always_comb begin
      hp        = {1'b0, half};
      per       = hp + hp;
      on_len    = hp - DEAD;
      cnt_d     = (!en || first || cnt_q == per - ONE) ? '0 : cnt_q + ONE;
      lo_p_d    = en && cnt_d < on_len;
      lo_n_d    = en && cnt_d >= hp && cnt_d < hp + on_len;
      lo_sync_d = en && cnt_d == '0;
   end
   // registered LO drive so both switches change only on clock edges
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         lo_p_q    <= 1'b0;
         lo_n_q    <= 1'b0;
         lo_sync_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         lo_p_q    <= lo_p_d;
         lo_n_q    <= lo_n_d;
         lo_sync_q <= lo_sync_d;
      end
   end
   assign period_end = cnt_q == per - ONE;
   assign lo_p       = lo_p_q;
   assign lo_n       = lo_n_q;
   assign lo_sync    = lo_sync_q;
endmodule

// File: rtl/mixer_lo_sequencer.sv
// mixer_lo_sequencer: bias/settle/LO-run/done sequencer for the Gilbert mixer test cell
module mixer_lo_sequencer
   import mixer_seq_pkg::*;
#(
   parameter int CNT_W    = 16,
   parameter int SETTLE_W = 16,
   parameter int DEAD_CYC = DEAD_CYC_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic [CNT_W-1:0]    half_period,
   input  logic [SETTLE_W-1:0] settle_cycles,
   input  logic [CNT_W-1:0]    run_cycles,
   output logic                bias_en,
   output logic                lo_p,
   output logic                lo_n,
   output logic                lo_sync,
   output logic                busy,
   output logic                done,
   output logic                err
);
   localparam logic [CNT_W-1:0]    DEAD_W = CNT_W'(DEAD_CYC);
   localparam logic [CNT_W-1:0]    ONE_C  = CNT_W'(1);
   localparam logic [SETTLE_W-1:0] ONE_S  = SETTLE_W'(1);
   state_e state_q, state_d;
   logic [CNT_W-1:0] half_q, half_d, run_q, run_d, per_cnt_q, per_cnt_d;
   logic [SETTLE_W-1:0] settle_q, settle_d, settle_cnt_q, settle_cnt_d;
   logic err_q, err_d, bias_q, bias_d, busy_q, busy_d, done_q, done_d;
   logic period_end;
   // next-state, config latch and counter updates
   always_comb begin
      state_d      = state_q;
      half_d       = half_q;
      settle_d     = settle_q;
      run_d        = run_q;
      settle_cnt_d = settle_cnt_q;
      per_cnt_d    = per_cnt_q;
      err_d        = err_q;
      if (state_q == IDLE) begin
         if (start && !abort) begin
            if (half_period <= DEAD_W) begin
               err_d = 1'b1;
            end else begin
               err_d        = 1'b0;
               state_d      = SETTLE;
               half_d       = half_period;
               settle_d     = settle_cycles;
               run_d        = run_cycles;
               settle_cnt_d = ONE_S;
            end
         end
      end else if (abort) begin
         state_d = IDLE;
      end else if (state_q == SETTLE) begin
         if (settle_cnt_q >= settle_q) begin
            state_d   = (run_q == '0) ? DONE : RUN;
            per_cnt_d = '0;
         end else begin
            settle_cnt_d = settle_cnt_q + ONE_S;
         end
      end else if (state_q == RUN) begin
         if (period_end) begin
            if (per_cnt_q + ONE_C == run_q) state_d = DONE;
            else per_cnt_d = per_cnt_q + ONE_C;
         end
      end else begin
         state_d = IDLE;
      end
      bias_d = state_d == SETTLE || state_d == RUN;
      busy_d = state_d != IDLE;
      done_d = state_d == DONE;
   end
   // state, config and registered status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         half_q       <= '0;
         settle_q     <= '0;
         run_q        <= '0;
         settle_cnt_q <= '0;
         per_cnt_q    <= '0;
         err_q        <= 1'b0;
         bias_q       <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         half_q       <= half_d;
         settle_q     <= settle_d;
         run_q        <= run_d;
         settle_cnt_q <= settle_cnt_d;
         per_cnt_q    <= per_cnt_d;
         err_q        <= err_d;
         bias_q       <= bias_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end
   lo_phase_gen #(.CNT_W(CNT_W), .DEAD_CYC(DEAD_CYC)) u_phase (
      .clk        (clk),
      .rst        (rst),
      .en         (state_d == RUN),
      .first      (state_q != RUN),
      .half       (half_q),
      .lo_p       (lo_p),
      .lo_n       (lo_n),
      .lo_sync    (lo_sync),
      .period_end (period_end)
   );
   assign bias_en = bias_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign err     = err_q;
endmodule
